// File: rtl/encrypt_pkg.sv
// Shared types and constants for the shift (Caesar) encryption pipe stages.
package encrypt_pkg;

    localparam int ALPHA_LEN = 26;

    localparam logic [7:0] ASCII_UPPER_A = 8'd65;
    localparam logic [7:0] ASCII_LOWER_A = 8'd97;

    typedef logic [4:0]  letter_idx_t;
    typedef logic [25:0] onehot26_t;

endpackage

// File: rtl/encrypt_rot26.sv
// Combinational modulo-26 rotate of a one-hot letter vector plus the
// one-hot to index encoder. "valid" is high only when exactly one bit is set.
module encrypt_rot26
    import encrypt_pkg::*;
(
    input  onehot26_t   vec,
    input  letter_idx_t eff,
    output letter_idx_t idx,
    output logic        valid
);

    onehot26_t  rotated;
    logic [4:0] ones;

    // Rotate left by eff within 26 bits: the doubled vector shifted left, upper half kept.
    always_comb begin
        rotated = onehot26_t'(({vec, vec} << eff) >> ALPHA_LEN);
    end

    // Encode the set bit position and count set bits to detect a malformed vector.
    always_comb begin
        idx  = '0;
        ones = '0;
        for (int i = 0; i < ALPHA_LEN; i++) begin
            if (rotated[i]) begin
                idx  = letter_idx_t'(i);
                ones = ones + 5'd1;
            end
        end
        valid = (ones == 5'd1);
    end

endmodule

// File: rtl/encrypt_pipe_shift_rot.sv
// Second pipe stage of the shift encryption path: rotates the one-hot letter
// by static shift plus a rolling offset, re-encodes to ASCII and registers
// the result with the key and control pass-throughs.
module encrypt_pipe_shift_rot
    import encrypt_pkg::*;
#(
    parameter bit ROLL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        mode,
    input  logic        shift_en,
    input  logic [3:0]  shift_amt,
    input  logic [2:0]  rot_freq,
    input  logic [7:0]  k1,
    input  logic [7:0]  k2,
    input  logic [7:0]  k3,
    input  logic        is_alpha_upper_case,
    input  logic        is_alpha_low_case,
    input  logic [31:0] extended_shift_data,
    output logic [7:0]  k1_out,
    output logic [7:0]  k2_out,
    output logic [7:0]  k3_out,
    output logic [2:0]  rot_freq_out,
    output logic        mode_out,
    output logic        en_out,
    output logic [7:0]  dout,
    output logic        onehot_err_out,
    output logic [4:0]  offset_out
);

    logic [2:0]  char_cnt;
    letter_idx_t offset;

    logic        act;
    logic        alpha;
    logic [5:0]  sum;
    letter_idx_t eff;
    letter_idx_t rot_idx;
    logic        rot_valid;
    logic [7:0]  dout_d;
    logic        err_d;
    logic        unused_hi_bits;

    assign act            = en & mode & shift_en;
    assign alpha          = act & (is_alpha_upper_case | is_alpha_low_case);
    assign unused_hi_bits = ^extended_shift_data[31:26];
    assign offset_out     = offset;

    // Effective shift folded back into 0..25 (sum never exceeds 40, one subtract suffices).
    always_comb begin
        sum = {2'b00, shift_amt} + {1'b0, offset};
        eff = (sum >= 6'd26) ? letter_idx_t'(sum - 6'd26) : letter_idx_t'(sum);
    end

    encrypt_rot26 u_rot26 (
        .vec   (extended_shift_data[25:0]),
        .eff   (eff),
        .idx   (rot_idx),
        .valid (rot_valid)
    );

    // Select the output byte and error flag; upper case wins when both flags are set.
    always_comb begin
        dout_d = '0;
        err_d  = 1'b0;
        if (en && mode) begin
            if (!alpha) begin
                dout_d = extended_shift_data[7:0];
            end else if (!rot_valid) begin
                dout_d = '0;
                err_d  = 1'b1;
            end else begin
                err_d = is_alpha_upper_case & is_alpha_low_case;
                if (is_alpha_upper_case) begin
                    dout_d = ASCII_UPPER_A + {3'b000, rot_idx};
                end else begin
                    dout_d = ASCII_LOWER_A + {3'b000, rot_idx};
                end
            end
        end
    end

    // Output register stage; pass-throughs are captured every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k1_out         <= '0;
            k2_out         <= '0;
            k3_out         <= '0;
            rot_freq_out   <= '0;
            mode_out       <= 1'b0;
            en_out         <= 1'b0;
            dout           <= '0;
            onehot_err_out <= 1'b0;
        end else begin
            k1_out         <= k1;
            k2_out         <= k2;
            k3_out         <= k3;
            rot_freq_out   <= rot_freq;
            mode_out       <= mode;
            en_out         <= en;
            dout           <= dout_d;
            onehot_err_out <= err_d;
        end
    end

    // Rolling offset: steps every rot_freq letters; ">=" lets a lowered rot_freq wrap promptly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            char_cnt <= '0;
            offset   <= '0;
        end else if (!ROLL_EN || rot_freq == 3'd0) begin
            char_cnt <= '0;
            offset   <= '0;
        end else if (alpha) begin
            if (char_cnt >= rot_freq - 3'd1) begin
                char_cnt <= '0;
                offset   <= (offset == 5'd25) ? 5'd0 : offset + 5'd1;
            end else begin
                char_cnt <= char_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_encrypt_pipe_shift_rot.sv
// Self-checking bench for encrypt_pipe_shift_rot: directed scenarios plus a
// randomized stream, all checked against a letter-arithmetic reference model.
module tb_encrypt_pipe_shift_rot;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mode;
    logic        shift_en;
    logic [3:0]  shift_amt;
    logic [2:0]  rot_freq;
    logic [7:0]  k1, k2, k3;
    logic        is_alpha_upper_case;
    logic        is_alpha_low_case;
    logic [31:0] extended_shift_data;
    logic [7:0]  k1_out, k2_out, k3_out;
    logic [2:0]  rot_freq_out;
    logic        mode_out;
    logic        en_out;
    logic [7:0]  dout;
    logic        onehot_err_out;
    logic [4:0]  offset_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_cnt = 0;
    int m_off = 0;

    // Expected outputs after the next clock edge
    logic [7:0] exp_dout;
    logic       exp_err;
    logic [4:0] exp_offset;
    logic [7:0] exp_k1, exp_k2, exp_k3;
    logic [2:0] exp_rf;
    logic       exp_mode, exp_en;

    encrypt_pipe_shift_rot #(.ROLL_EN(1'b1)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .mode                (mode),
        .shift_en            (shift_en),
        .shift_amt           (shift_amt),
        .rot_freq            (rot_freq),
        .k1                  (k1),
        .k2                  (k2),
        .k3                  (k3),
        .is_alpha_upper_case (is_alpha_upper_case),
        .is_alpha_low_case   (is_alpha_low_case),
        .extended_shift_data (extended_shift_data),
        .k1_out              (k1_out),
        .k2_out              (k2_out),
        .k3_out              (k3_out),
        .rot_freq_out        (rot_freq_out),
        .mode_out            (mode_out),
        .en_out              (en_out),
        .dout                (dout),
        .onehot_err_out      (onehot_err_out),
        .offset_out          (offset_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, predict the registered result, and step past the edge.
    task automatic drive(input logic e, input logic m, input logic se,
                         input logic [3:0] sa, input logic [2:0] rf,
                         input logic up, input logic lo, input logic [31:0] d);
        int ones;
        int letter;
        int shift;
        logic alpha;
        en = e; mode = m; shift_en = se; shift_amt = sa; rot_freq = rf;
        is_alpha_upper_case = up; is_alpha_low_case = lo; extended_shift_data = d;
        k1 = 8'($urandom); k2 = 8'($urandom); k3 = 8'($urandom);
        exp_k1 = k1; exp_k2 = k2; exp_k3 = k3;
        exp_rf = rf; exp_mode = m; exp_en = e;

        alpha  = e && m && se && (up || lo);
        ones   = 0;
        letter = 0;
        for (int i = 0; i < 26; i++) begin
            if (d[i]) begin
                ones++;
                letter = i;
            end
        end

        if (!(e && m)) begin
            exp_dout = 8'd0;
            exp_err  = 1'b0;
        end else if (!alpha) begin
            exp_dout = d[7:0];
            exp_err  = 1'b0;
        end else if (ones != 1) begin
            exp_dout = 8'd0;
            exp_err  = 1'b1;
        end else begin
            shift    = (int'(sa) + m_off) % 26;
            exp_dout = 8'((up ? 65 : 97) + (letter + shift) % 26);
            exp_err  = up && lo;
        end

        if (rf == 3'd0) begin
            m_cnt = 0;
            m_off = 0;
        end else if (alpha) begin
            m_cnt++;
            if (m_cnt >= int'(rf)) begin
                m_cnt = 0;
                m_off = (m_off + 1) % 26;
            end
        end
        exp_offset = 5'(m_off);

        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 4'd3, 3'd2, 1'b1, 1'b0, 32'h1);
        @(posedge clk);
        #1;
        n_checks++;
        if (dout !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_dout: got %0d expected 0", dout); end
        n_checks++;
        if (onehot_err_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %0b expected 0", onehot_err_out); end
        n_checks++;
        if (en_out !== 1'b0 || mode_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ctrl: got en=%0b mode=%0b expected 0/0", en_out, mode_out); end
        n_checks++;
        if ({k1_out, k2_out, k3_out} !== 24'd0 || rot_freq_out !== 3'd0) begin
            n_fail++; $display("[TB] FAIL reset_keys: got %0h/%0d expected 0/0", {k1_out, k2_out, k3_out}, rot_freq_out);
        end
        n_checks++;
        if (offset_out !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_offset: got %0d expected 0", offset_out); end
        @(negedge clk);
        rst   = 1'b1;
        m_cnt = 0;
        m_off = 0;
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b1, 1'b1, 4'd3, 3'd0, 1'b1, 1'b0, 32'h1);
        n_checks++;
        if (dout !== 8'd68) begin n_fail++; $display("[TB] FAIL basic_A_plus3: got %0d expected 68", dout); end
        n_checks++;
        if (en_out !== 1'b1 || onehot_err_out !== 1'b0) begin
            n_fail++; $display("[TB] FAIL basic_flags: got en=%0b err=%0b expected 1/0", en_out, onehot_err_out);
        end
        n_checks++;
        if ({k1_out, k2_out, k3_out, rot_freq_out, mode_out} !== {exp_k1, exp_k2, exp_k3, exp_rf, exp_mode}) begin
            n_fail++; $display("[TB] FAIL basic_passthru: got %0h expected %0h",
                {k1_out, k2_out, k3_out, rot_freq_out, mode_out}, {exp_k1, exp_k2, exp_k3, exp_rf, exp_mode});
        end
        drive(1'b1, 1'b1, 1'b1, 4'd1, 3'd0, 1'b0, 1'b1, 32'h1 << 25);
        n_checks++;
        if (dout !== 8'd97) begin n_fail++; $display("[TB] FAIL basic_z_wrap: got %0d expected 97", dout); end
    endtask

    task automatic test_rolling();
        logic [7:0] want_dout [4];
        logic [4:0] want_off  [4];
        want_dout = '{8'd97, 8'd97, 8'd98, 8'd98};
        want_off  = '{5'd0, 5'd1, 5'd1, 5'd2};
        drive(1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 4'd0, 3'd2, 1'b0, 1'b1, 32'h1);
            n_checks++;
            if (dout !== want_dout[i] || offset_out !== want_off[i]) begin
                n_fail++; $display("[TB] FAIL rolling_%0d: got dout=%0d off=%0d expected %0d/%0d",
                    i, dout, offset_out, want_dout[i], want_off[i]);
            end
        end
    endtask

    task automatic test_offset_wrap();
        drive(1'b0, 1'b1, 1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 25; i++) drive(1'b1, 1'b1, 1'b1, 4'd0, 3'd1, 1'b0, 1'b1, 32'h1);
        n_checks++;
        if (offset_out !== 5'd25) begin n_fail++; $display("[TB] FAIL wrap_reach25: got %0d expected 25", offset_out); end
        drive(1'b1, 1'b1, 1'b1, 4'd15, 3'd1, 1'b1, 1'b0, 32'h1);
        n_checks++;
        if (dout !== 8'd79) begin n_fail++; $display("[TB] FAIL wrap_eff14: got %0d expected 79", dout); end
        n_checks++;
        if (offset_out !== 5'd0) begin n_fail++; $display("[TB] FAIL wrap_offset0: got %0d expected 0", offset_out); end
    endtask

    task automatic test_non_alpha();
        logic [4:0] prev;
        drive(1'b1, 1'b1, 1'b1, 4'd2, 3'd1, 1'b0, 1'b1, 32'h1 << 2);
        n_checks++;
        if (dout !== exp_dout) begin n_fail++; $display("[TB] FAIL nonalpha_pre: got %0d expected %0d", dout, exp_dout); end
        prev = offset_out;
        drive(1'b1, 1'b1, 1'b1, 4'd2, 3'd1, 1'b0, 1'b0, 32'd53);
        n_checks++;
        if (dout !== 8'd53) begin n_fail++; $display("[TB] FAIL nonalpha_byte: got %0d expected 53", dout); end
        n_checks++;
        if (offset_out !== prev || offset_out !== exp_offset) begin
            n_fail++; $display("[TB] FAIL nonalpha_offset_hold: got %0d expected %0d", offset_out, exp_offset);
        end
        drive(1'b1, 1'b1, 1'b1, 4'd2, 3'd1, 1'b1, 1'b0, 32'h1 << 7);
        n_checks++;
        if (dout !== exp_dout || offset_out !== exp_offset) begin
            n_fail++; $display("[TB] FAIL nonalpha_post: got %0d/%0d expected %0d/%0d", dout, offset_out, exp_dout, exp_offset);
        end
    endtask

    task automatic test_error();
        drive(1'b1, 1'b1, 1'b1, 4'd0, 3'd0, 1'b1, 1'b0, 32'h3);
        n_checks++;
        if (dout !== 8'd0 || onehot_err_out !== 1'b1) begin
            n_fail++; $display("[TB] FAIL err_not_onehot: got %0d/%0b expected 0/1", dout, onehot_err_out);
        end
        drive(1'b1, 1'b1, 1'b1, 4'd0, 3'd0, 1'b1, 1'b1, 32'h1 << 4);
        n_checks++;
        if (dout !== 8'd69 || onehot_err_out !== 1'b1) begin
            n_fail++; $display("[TB] FAIL err_both_flags: got %0d/%0b expected 69/1", dout, onehot_err_out);
        end
        drive(1'b1, 1'b1, 1'b0, 4'd5, 3'd0, 1'b1, 1'b0, 32'h41);
        n_checks++;
        if (dout !== 8'h41 || onehot_err_out !== 1'b0) begin
            n_fail++; $display("[TB] FAIL shift_disabled: got %0d/%0b expected 65/0", dout, onehot_err_out);
        end
        drive(1'b1, 1'b0, 1'b1, 4'd5, 3'd0, 1'b1, 1'b0, 32'h3);
        n_checks++;
        if (dout !== 8'd0 || onehot_err_out !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mode_off: got %0d/%0b expected 0/0", dout, onehot_err_out);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 4'd0, 3'd1, 1'b1, 1'b0, 32'h1);
        n_checks++;
        if (offset_out !== 5'd3) begin n_fail++; $display("[TB] FAIL midrst_pre_offset: got %0d expected 3", offset_out); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (dout !== 8'd0 || offset_out !== 5'd0 || en_out !== 1'b0 || k1_out !== 8'd0) begin
            n_fail++; $display("[TB] FAIL midrst_async_clear: got dout=%0d off=%0d en=%0b k1=%0d expected 0",
                dout, offset_out, en_out, k1_out);
        end
        @(negedge clk);
        rst   = 1'b1;
        m_cnt = 0;
        m_off = 0;
        drive(1'b1, 1'b1, 1'b1, 4'd0, 3'd1, 1'b1, 1'b0, 32'h1);
        n_checks++;
        if (dout !== 8'd65 || offset_out !== 5'd1) begin
            n_fail++; $display("[TB] FAIL midrst_first_char: got %0d/%0d expected 65/1", dout, offset_out);
        end
    endtask

    task automatic test_random();
        logic [2:0]  rf;
        logic [31:0] d;
        logic        up, lo;
        int          r;
        rf = 3'd3;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) rf = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            up = (r < 4) || (r == 8);
            lo = (r >= 4 && r < 8) || (r == 8);
            if ($urandom_range(0, 19) < 17) d = ($urandom << 26) | (32'h1 << $urandom_range(0, 25));
            else d = $urandom;
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                  4'($urandom), rf, up, lo, d);
            n_checks++;
            if (dout !== exp_dout || onehot_err_out !== exp_err || offset_out !== exp_offset) begin
                n_fail++; $display("[TB] FAIL random_%0d_data: got %0d/%0b/%0d expected %0d/%0b/%0d",
                    n, dout, onehot_err_out, offset_out, exp_dout, exp_err, exp_offset);
            end
            n_checks++;
            if ({k1_out, k2_out, k3_out, rot_freq_out, mode_out, en_out} !==
                {exp_k1, exp_k2, exp_k3, exp_rf, exp_mode, exp_en}) begin
                n_fail++; $display("[TB] FAIL random_%0d_passthru: got %0h expected %0h", n,
                    {k1_out, k2_out, k3_out, rot_freq_out, mode_out, en_out},
                    {exp_k1, exp_k2, exp_k3, exp_rf, exp_mode, exp_en});
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0; mode = 1'b0; shift_en = 1'b0; shift_amt = '0; rot_freq = '0;
        k1 = '0; k2 = '0; k3 = '0;
        is_alpha_upper_case = 1'b0; is_alpha_low_case = 1'b0; extended_shift_data = '0;
        #1;
        test_reset();
        test_basic();
        test_rolling();
        test_offset_wrap();
        test_non_alpha();
        test_error();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
